win33_atma: RTL and testbench

WIN33_ATMA -- requirements
Module: win33_atma

---
 rtl/win_pkg.sv | 19 +
 rtl/win33_atma_xform.sv | 49 ++++
 rtl/win33_atma.sv | 108 ++++++++++
 tb/tb_win33_atma.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/win_pkg.sv
// Shared widths, lane-position helper and y_out lane indices for the win33 A^T M A blocks.
// Lanes are packed with index 0 in the MSBs.
package win_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ACC_W  = 32;
    localparam int unsigned LANES  = 4;

    localparam int unsigned Y11 = 0;
    localparam int unsigned Y12 = 1;
    localparam int unsigned Y21 = 2;
    localparam int unsigned Y22 = 3;

    // Bit offset of lane idx in a 4-lane vector of w-bit lanes, lane 0 in the MSBs.
    function automatic int unsigned lane_lsb(input int unsigned idx, input int unsigned w);
        return (LANES - 1 - idx) * w;
    endfunction

endpackage

// File: rtl/win33_atma_xform.sv
// Combinational A^T M A kernel: row transform of a 4x4 tile into t1/t2, and column
// transform of registered t1/t2 into the 2x2 output lanes.
module win33_atma_xform #(
    parameter int unsigned DATA_W = win_pkg::DATA_W,
    parameter int unsigned ACC_W  = win_pkg::ACC_W
) (
    input  logic [4*DATA_W-1:0] m1,
    input  logic [4*DATA_W-1:0] m2,
    input  logic [4*DATA_W-1:0] m3,
    input  logic [4*DATA_W-1:0] m4,
    output logic [4*ACC_W-1:0]  t1,
    output logic [4*ACC_W-1:0]  t2,
    input  logic [4*ACC_W-1:0]  s1,
    input  logic [4*ACC_W-1:0]  s2,
    output logic [4*ACC_W-1:0]  y
);
    import win_pkg::*;

    function automatic logic [ACC_W-1:0] sext(input logic [DATA_W-1:0] v);
        return ACC_W'($signed(v));
    endfunction

    function automatic logic [ACC_W-1:0] lane(input logic [4*ACC_W-1:0] v,
                                              input int unsigned idx);
        return v[lane_lsb(idx, ACC_W) +: ACC_W];
    endfunction

    always_comb begin
        t1 = '0;
        t2 = '0;
        for (int unsigned j = 0; j < LANES; j++) begin
            t1[lane_lsb(j, ACC_W) +: ACC_W] = sext(m1[lane_lsb(j, DATA_W) +: DATA_W])
                                            + sext(m2[lane_lsb(j, DATA_W) +: DATA_W])
                                            + sext(m3[lane_lsb(j, DATA_W) +: DATA_W]);
            t2[lane_lsb(j, ACC_W) +: ACC_W] = sext(m2[lane_lsb(j, DATA_W) +: DATA_W])
                                            - sext(m3[lane_lsb(j, DATA_W) +: DATA_W])
                                            - sext(m4[lane_lsb(j, DATA_W) +: DATA_W]);
        end
    end

    always_comb begin
        y = '0;
        y[lane_lsb(Y11, ACC_W) +: ACC_W] = lane(s1, 0) + lane(s1, 1) + lane(s1, 2);
        y[lane_lsb(Y12, ACC_W) +: ACC_W] = lane(s1, 1) - lane(s1, 2) - lane(s1, 3);
        y[lane_lsb(Y21, ACC_W) +: ACC_W] = lane(s2, 0) + lane(s2, 1) + lane(s2, 2);
        y[lane_lsb(Y22, ACC_W) +: ACC_W] = lane(s2, 1) - lane(s2, 2) - lane(s2, 3);
    end

endmodule

// File: rtl/win33_atma.sv
// Two-stage accumulate-and-emit pipeline around the A^T M A kernel: stage 1 holds the
// row transform, stage 2 folds the column transform into the per-tile accumulator.
module win33_atma #(
    parameter int unsigned DATA_W = win_pkg::DATA_W,
    parameter int unsigned ACC_W  = win_pkg::ACC_W,
    parameter bit          RELU   = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                m_valid,
    output logic                m_ready,
    input  logic                m_last,
    input  logic [4*DATA_W-1:0] m1,
    input  logic [4*DATA_W-1:0] m2,
    input  logic [4*DATA_W-1:0] m3,
    input  logic [4*DATA_W-1:0] m4,
    output logic                y_valid,
    input  logic                y_ready,
    output logic [4*ACC_W-1:0]  y_out,
    output logic [15:0]         tile_cnt
);
    import win_pkg::*;

    logic                 stall;
    logic                 accept;
    logic [4*ACC_W-1:0]   t1, t2;
    logic [4*ACC_W-1:0]   col;
    logic                 s1_valid;
    logic                 s1_last;
    logic [4*ACC_W-1:0]   s1_t1, s1_t2;
    logic [4*ACC_W-1:0]   acc;
    logic [4*ACC_W-1:0]   acc_sum;
    logic [4*ACC_W-1:0]   y_next;

    assign stall   = y_valid && !y_ready;
    assign m_ready = !stall && !clr;
    assign accept  = m_valid && m_ready;

    win33_atma_xform #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_xform (
        .m1 (m1),
        .m2 (m2),
        .m3 (m3),
        .m4 (m4),
        .t1 (t1),
        .t2 (t2),
        .s1 (s1_t1),
        .s2 (s1_t2),
        .y  (col)
    );

    // Clamping applies only to the emitted tile, never to the running accumulator.
    always_comb begin
        acc_sum = '0;
        y_next  = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            acc_sum[lane_lsb(i, ACC_W) +: ACC_W] = acc[lane_lsb(i, ACC_W) +: ACC_W]
                                                 + col[lane_lsb(i, ACC_W) +: ACC_W];
            if (RELU && acc_sum[lane_lsb(i, ACC_W) + ACC_W - 1]) begin
                y_next[lane_lsb(i, ACC_W) +: ACC_W] = '0;
            end else begin
                y_next[lane_lsb(i, ACC_W) +: ACC_W] = acc_sum[lane_lsb(i, ACC_W) +: ACC_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_t1    <= '0;
            s1_t2    <= '0;
            acc      <= '0;
            y_out    <= '0;
            y_valid  <= 1'b0;
            tile_cnt <= '0;
        end else if (clr) begin
            s1_valid <= 1'b0;
            acc      <= '0;
            if (y_ready) begin
                y_valid <= 1'b0;
            end
        end else if (!stall) begin
            s1_valid <= accept;
            if (accept) begin
                s1_t1   <= t1;
                s1_t2   <= t2;
                s1_last <= m_last;
            end
            // Not stalled means the held tile (if any) is consumed on this edge.
            y_valid <= 1'b0;
            if (s1_valid) begin
                if (s1_last) begin
                    y_out    <= y_next;
                    y_valid  <= 1'b1;
                    acc      <= '0;
                    tile_cnt <= tile_cnt + 16'd1;
                end else begin
                    acc <= acc_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_win33_atma.sv
// Self-checking bench for win33_atma: directed vector table, back-pressure and flush
// sequences, then randomized traffic against a tile-level A^T M A scoreboard.
module tb_win33_atma;
    localparam int DW = 16;
    localparam int AW = 32;

    typedef logic [4*DW-1:0] row_t;
    typedef logic [4*AW-1:0] tile_t;

    typedef struct {
        string name;
        row_t  r1, r2, r3, r4;
        tile_t exp;
        tile_t exp_r;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, clr, m_valid, m_last, y_ready;
    row_t        m1, m2, m3, m4;
    logic        m_ready, m_ready_r, y_valid, y_valid_r;
    tile_t       y_out, y_out_r;
    logic [15:0] tile_cnt, tile_cnt_r;

    int          n_tests = 0;
    int          n_fail  = 0;

    tile_t       exp_q[$];
    tile_t       part;
    logic [15:0] exp_cnt;
    logic        hold_chk;
    tile_t       held_y;

    always #5 clk = ~clk;

    win33_atma #(.DATA_W(DW), .ACC_W(AW), .RELU(1'b0)) dut (
        .clk(clk), .rst(rst), .clr(clr), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .m1(m1), .m2(m2), .m3(m3), .m4(m4), .y_valid(y_valid),
        .y_ready(y_ready), .y_out(y_out), .tile_cnt(tile_cnt)
    );

    win33_atma #(.DATA_W(DW), .ACC_W(AW), .RELU(1'b1)) dut_r (
        .clk(clk), .rst(rst), .clr(clr), .m_valid(m_valid), .m_ready(m_ready_r),
        .m_last(m_last), .m1(m1), .m2(m2), .m3(m3), .m4(m4), .y_valid(y_valid_r),
        .y_ready(y_ready), .y_out(y_out_r), .tile_cnt(tile_cnt_r)
    );

    task automatic check(input string name, input tile_t act, input tile_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic tile_t pack4(input int a, input int b, input int c, input int d);
        return {a, b, c, d};
    endfunction

    // y[p][q] = sum_i sum_j A[i][p] * M[i][j] * A[j][q]
    function automatic tile_t ref_xform(input row_t r1, input row_t r2, input row_t r3,
                                        input row_t r4);
        row_t                 rows[4];
        int                   coef[2][4];
        logic signed [AW-1:0] x, sum;
        tile_t                y;
        rows[0] = r1; rows[1] = r2; rows[2] = r3; rows[3] = r4;
        coef = '{'{1, 1, 1, 0}, '{0, 1, -1, -1}};
        y = '0;
        for (int p = 0; p < 2; p++) begin
            for (int q = 0; q < 2; q++) begin
                sum = '0;
                for (int i = 0; i < 4; i++) begin
                    for (int j = 0; j < 4; j++) begin
                        x = AW'($signed(rows[i][(3-j)*DW +: DW]));
                        sum = sum + x * coef[p][i] * coef[q][j];
                    end
                end
                y[(3-(2*p+q))*AW +: AW] = sum;
            end
        end
        return y;
    endfunction

    function automatic tile_t add_tiles(input tile_t a, input tile_t b);
        tile_t s;
        for (int i = 0; i < 4; i++) s[i*AW +: AW] = a[i*AW +: AW] + b[i*AW +: AW];
        return s;
    endfunction

    function automatic tile_t relu_tile(input tile_t a);
        tile_t s;
        s = a;
        for (int i = 0; i < 4; i++) if (a[i*AW + AW - 1]) s[i*AW +: AW] = '0;
        return s;
    endfunction

    // Scoreboard: sampled mid-cycle, i.e. what the DUT sees at the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            part     = '0;
            exp_cnt  = '0;
            hold_chk = 1'b0;
        end else begin
            check("m_ready", m_ready, tile_t'(!(y_valid && !y_ready) && !clr));
            if (hold_chk) check("hold_y_out", y_out, held_y);
            hold_chk = y_valid && !y_ready;
            held_y   = y_out;
            if (y_valid && y_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_tile: got %h, expected no tile", y_out);
                end else begin
                    tile_t e;
                    e = exp_q.pop_front();
                    exp_cnt = exp_cnt + 16'd1;
                    check("sb_y_out", y_out, e);
                    check("sb_y_out_relu", y_out_r, relu_tile(e));
                    check("sb_tile_cnt", tile_t'(tile_cnt), tile_t'(exp_cnt));
                end
            end
            if (clr) begin
                part = '0;
            end else if (m_valid && m_ready) begin
                part = add_tiles(part, ref_xform(m1, m2, m3, m4));
                if (m_last) begin
                    exp_q.push_back(part);
                    part = '0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input row_t a, input row_t b, input row_t c, input row_t d,
                        input logic last);
        int n;
        n = 0;
        m1 = a; m2 = b; m3 = c; m4 = d;
        m_last  = last;
        m_valid = 1'b1;
        #1;
        while (!m_ready && n < 50) begin
            tick();
            n++;
        end
        if (!m_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: m_ready got 0, expected 1");
        end
        tick();
        m_valid = 1'b0;
        m_last  = 1'b0;
    endtask

    task automatic expect_tile(input string name, input tile_t e, input tile_t er);
        int n;
        n = 0;
        while (!y_valid && n < 20) begin
            tick();
            n++;
        end
        check({name, "_valid"}, tile_t'(y_valid), tile_t'(1));
        check(name, y_out, e);
        check({name, "_relu"}, y_out_r, er);
        y_ready = 1'b1;
        tick();
        y_ready = 1'b0;
    endtask

    row_t ones, sev, zero;
    vec_t vecs[4];

    initial begin
        ones = {4{16'h0001}};
        sev  = {4{16'h0007}};
        zero = '0;
        vecs[0] = '{"all_ones", ones, ones, ones, ones,
                    pack4(9, -3, -3, 1), pack4(9, 0, 0, 1)};
        vecs[1] = '{"m1_1_eq5", {16'd5, 48'd0}, zero, zero, zero,
                    pack4(5, 0, 0, 0), pack4(5, 0, 0, 0)};
        vecs[2] = '{"m4_4_eq7", zero, zero, zero, {48'd0, 16'd7},
                    pack4(0, 0, 0, 7), pack4(0, 0, 0, 7)};
        vecs[3] = '{"all_min", {4{16'h8000}}, {4{16'h8000}}, {4{16'h8000}}, {4{16'h8000}},
                    pack4(-294912, 98304, 98304, -32768), pack4(0, 98304, 98304, 0)};

        rst = 1'b1; clr = 1'b0; m_valid = 1'b0; m_last = 1'b0; y_ready = 1'b0;
        m1 = '0; m2 = '0; m3 = '0; m4 = '0;
        tick();
        tick();
        check("rst_y_valid", tile_t'(y_valid), '0);
        check("rst_y_out", y_out, '0);
        check("rst_tile_cnt", tile_t'(tile_cnt), '0);
        rst = 1'b0;
        #1;
        check("rst_m_ready", tile_t'(m_ready), tile_t'(1));

        // Two-beat tile accumulates.
        send(ones, ones, ones, ones, 1'b0);
        send(ones, ones, ones, ones, 1'b1);
        expect_tile("two_beat", pack4(18, -6, -6, 2), pack4(18, 0, 0, 2));
        check("two_beat_cnt", tile_t'(tile_cnt), tile_t'(1));

        // Accept-to-output latency.
        send(ones, ones, ones, ones, 1'b1);
        check("lat_edge1_valid", tile_t'(y_valid), '0);
        tick();
        check("lat_edge2_valid", tile_t'(y_valid), tile_t'(1));
        expect_tile("lat_tile", pack4(9, -3, -3, 1), pack4(9, 0, 0, 1));

        for (int i = 0; i < 4; i++) begin
            send(vecs[i].r1, vecs[i].r2, vecs[i].r3, vecs[i].r4, 1'b1);
            expect_tile(vecs[i].name, vecs[i].exp, vecs[i].exp_r);
        end

        // Back-pressure: second tile waits while the first is held.
        send(ones, ones, ones, ones, 1'b1);
        tick();
        m1 = {16'd5, 48'd0}; m2 = zero; m3 = zero; m4 = zero;
        m_last = 1'b1; m_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_m_ready", tile_t'(m_ready), '0);
            check("bp_y_valid", tile_t'(y_valid), tile_t'(1));
            check("bp_held", y_out, pack4(9, -3, -3, 1));
            tick();
        end
        y_ready = 1'b1;
        #1;
        check("bp_release_ready", tile_t'(m_ready), tile_t'(1));
        tick();
        m_valid = 1'b0; m_last = 1'b0; y_ready = 1'b0;
        expect_tile("bp_second", pack4(5, 0, 0, 0), pack4(5, 0, 0, 0));

        // Flush mid-tile: rst, clr on stage-1 beat, clr after accumulation.
        for (int mode = 0; mode < 3; mode++) begin
            send(sev, sev, sev, sev, 1'b0);
            if (mode == 2) tick();
            if (mode == 0) rst = 1'b1;
            else clr = 1'b1;
            tick();
            rst = 1'b0;
            clr = 1'b0;
            if (mode == 0) check("flush_rst_cnt", tile_t'(tile_cnt), '0);
            send(ones, ones, ones, ones, 1'b1);
            expect_tile("post_flush", pack4(9, -3, -3, 1), pack4(9, 0, 0, 1));
        end

        // Randomized traffic against the scoreboard.
        for (int c = 0; c < 600; c++) begin
            m1 = {$urandom, $urandom}; m2 = {$urandom, $urandom};
            m3 = {$urandom, $urandom}; m4 = {$urandom, $urandom};
            m_valid = ($urandom % 4) != 0;
            m_last  = ($urandom % 3) == 0;
            y_ready = ($urandom % 3) != 0;
            tick();
        end
        m_valid = 1'b0;
        m_last  = 1'b1;
        y_ready = 1'b1;
        for (int n = 0; n < 50 && (exp_q.size() != 0 || y_valid); n++) tick();
        check("drain_queue", tile_t'(exp_q.size()), '0);
        check("drain_y_valid", tile_t'(y_valid), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation got no finish, expected finish before timeout");
        $fatal(1);
    end

endmodule
